// File: rtl/label_frame_writer_if.sv
// Label stream (valid/ready) and BRAM port-A write bus between the upstream source and the frame writer.
interface label_frame_writer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 3
);
  logic              pix_valid;
  logic              pix_sof;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output pix_valid, pix_sof, pix_data,
    input  pix_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  pix_valid, pix_sof, pix_data,
    output pix_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/label_frame_writer.sv
// Write side of the label framebuffer: raster-ordered label stream to linear BRAM writes,
// plus a full-frame clear to label 0.
module label_frame_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear_req,
  label_frame_writer_if.slave px,
  output logic                busy,
  output logic                frame_done,
  output logic                short_frame
);
  typedef enum logic [1:0] {WAIT_SOF, STREAM, CLEAR} state_t;

  localparam int                FRAME = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(FRAME - 1);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              short_q, short_d;
  logic              accept;

  assign accept = px.pix_valid & ready_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WAIT_SOF;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      short_q   <= short_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    short_d   = short_q;
    // A clear request wins over any pixel handshaking in the same cycle; that pixel is lost.
    if (clear_req) begin
      state_d = CLEAR;
      cnt_d   = '0;
      short_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_SOF: begin
          if (accept && px.pix_sof) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = px.pix_data;
            cnt_d     = ONE;
            state_d   = STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            wr_en_d   = 1'b1;
            wr_data_d = px.pix_data;
            if (px.pix_sof) begin
              short_d   = 1'b1;
              wr_addr_d = '0;
              cnt_d     = ONE;
            end else begin
              wr_addr_d = cnt_q;
              if (cnt_q == LAST) begin
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_SOF;
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end
          end
        end
        CLEAR: begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = '0;
          if (cnt_q == LAST) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_SOF;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: state_d = WAIT_SOF;
      endcase
    end
    // Ready drops together with entry to CLEAR and returns one cycle after leaving it.
    ready_d = (state_q != CLEAR) && (state_d != CLEAR);
    busy_d  = (state_d != WAIT_SOF);
  end

  assign px.pix_ready = ready_q;
  assign px.wr_en     = wr_en_q;
  assign px.wr_addr   = wr_addr_q;
  assign px.wr_data   = wr_data_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign short_frame  = short_q;
endmodule

// File: tb/tb_label_frame_writer.sv
// Randomized bench for label_frame_writer on a reduced 10x6 frame, checked against a pixel-position model.
module tb_label_frame_writer;
  localparam int H = 10;
  localparam int V = 6;
  localparam int AW = 6;
  localparam int DW = 3;
  localparam int FRAME = H * V;

  logic clock, reset_n, clear_req, busy, frame_done, short_frame;
  label_frame_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  label_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .px(bus.slave),
    .busy(busy), .frame_done(frame_done), .short_frame(short_frame)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Model: m_pos = next pixel index in the frame, -1 while waiting for a start-of-frame.
  int            m_pos;
  bit            m_clearing;
  int            m_cpos;
  bit            m_short, m_en, m_done, m_ready, m_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    m_pos = -1; m_clearing = 0; m_cpos = 0; m_short = 0;
    m_en = 0; m_done = 0; m_ready = 0; m_busy = 0; m_addr = '0; m_data = '0;
  endtask

  // Drives one clock of stimulus from a negedge, advances the model over the posedge, returns at the next negedge.
  task automatic cycle(input bit v, input bit s, input logic [DW-1:0] d, input bit clr);
    bit acc, was_clr;
    bus.pix_valid = v; bus.pix_sof = s; bus.pix_data = d; clear_req = clr;
    acc = v && m_ready;
    was_clr = m_clearing;
    @(posedge clock);
    m_en = 0; m_done = 0;
    if (clr) begin
      m_clearing = 1; m_cpos = 0; m_short = 0; m_pos = -1;
    end else if (m_clearing) begin
      m_en = 1; m_addr = AW'(m_cpos); m_data = '0; m_cpos++;
      if (m_cpos == FRAME) begin m_done = 1; m_clearing = 0; end
    end else if (acc) begin
      if (s) begin
        if (m_pos >= 0) m_short = 1;
        m_en = 1; m_addr = '0; m_data = d; m_pos = 1;
      end else if (m_pos >= 0) begin
        m_en = 1; m_addr = AW'(m_pos); m_data = d; m_pos++;
        if (m_pos == FRAME) begin m_done = 1; m_pos = -1; end
      end
    end
    m_ready = !m_clearing && !was_clr;
    m_busy = m_clearing || (m_pos >= 0);
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== '0 || bus.wr_data !== '0) begin bad++; $display("FAIL rst_wr: got en=%b addr=%0d data=%0d want 0/0/0", bus.wr_en, bus.wr_addr, bus.wr_data); end
    total++; if (bus.pix_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_ready_busy: got %b%b want 00", bus.pix_ready, busy); end
    total++; if (frame_done !== 1'b0 || short_frame !== 1'b0) begin bad++; $display("FAIL rst_flags: got %b%b want 00", frame_done, short_frame); end
    @(negedge clock); reset_n = 1'b1; model_reset();
    cycle(0, 0, 0, 0);
    total++; if (bus.pix_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_release: got ready=%b busy=%b want 1 0", bus.pix_ready, busy); end
    cycle(1, 1, 3, 0);
    for (int i = 1; i < 15; i++) cycle(1, 0, DW'(i), 0);
    total++; if (bus.wr_en !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rst_pre_stream: got en=%b busy=%b want 1 1", bus.wr_en, busy); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (bus.wr_en !== 1'b0 || bus.pix_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_async: got en=%b ready=%b busy=%b want 0 0 0", bus.wr_en, bus.pix_ready, busy); end
    @(negedge clock); reset_n = 1'b1; model_reset();
    cycle(1, 0, 1, 0);
    total++; if (bus.pix_ready !== 1'b1 || bus.wr_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_rerelease: got ready=%b en=%b busy=%b want 1 0 0", bus.pix_ready, bus.wr_en, busy); end
  endtask

  task automatic test_full_frame();
    int ndone = 0;
    logic [AW-1:0] done_addr = '0;
    for (int i = 0; i < FRAME; i++) begin
      cycle(1, i == 0, DW'(i % 8), 0);
      total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== AW'(i) || bus.wr_data !== DW'(i % 8)) begin bad++; $display("FAIL full_write: got en=%b addr=%0d data=%0d want 1 %0d %0d", bus.wr_en, bus.wr_addr, bus.wr_data, i, i % 8); end
      if (frame_done === 1'b1) begin ndone++; done_addr = bus.wr_addr; end
    end
    total++; if (ndone !== 1 || done_addr !== AW'(FRAME - 1)) begin bad++; $display("FAIL full_done: got count=%0d addr=%0d want 1 %0d", ndone, done_addr, FRAME - 1); end
    cycle(0, 0, 0, 0);
    total++; if (bus.wr_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL full_idle: got en=%b busy=%b done=%b want 0 0 0", bus.wr_en, busy, frame_done); end
  endtask

  task automatic test_pre_sof_junk();
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, DW'($urandom), 0);
      total++; if (bus.wr_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL junk_nowrite: got en=%b busy=%b want 0 0", bus.wr_en, busy); end
    end
    cycle(1, 1, 5, 0);
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== '0 || bus.wr_data !== DW'(5)) begin bad++; $display("FAIL junk_sof: got en=%b addr=%0d data=%0d want 1 0 5", bus.wr_en, bus.wr_addr, bus.wr_data); end
  endtask

  task automatic test_early_sof();
    int ndone = 0;
    for (int i = 1; i < 25; i++) cycle(1, 0, DW'($urandom), 0);
    cycle(1, 1, 6, 0);
    total++; if (short_frame !== 1'b1 || bus.wr_en !== 1'b1 || bus.wr_addr !== '0 || frame_done !== 1'b0) begin bad++; $display("FAIL early_sof: got short=%b en=%b addr=%0d done=%b want 1 1 0 0", short_frame, bus.wr_en, bus.wr_addr, frame_done); end
    for (int i = 1; i < FRAME; i++) begin
      cycle(1, 0, DW'($urandom), 0);
      total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== AW'(i) || bus.wr_data !== m_data || frame_done !== m_done) begin bad++; $display("FAIL early_write: got en=%b addr=%0d data=%0d done=%b want 1 %0d %0d %b", bus.wr_en, bus.wr_addr, bus.wr_data, frame_done, i, m_data, m_done); end
      if (frame_done === 1'b1) ndone++;
    end
    total++; if (ndone !== 1 || short_frame !== 1'b1) begin bad++; $display("FAIL early_done: got count=%0d short=%b want 1 1", ndone, short_frame); end
  endtask

  task automatic test_gaps();
    int sent = 0, ndone = 0, cyc = 0;
    bit v;
    while (sent < FRAME && cyc < 1000) begin
      v = ($urandom_range(0, 2) != 0);
      cycle(v, v && sent == 0, DW'($urandom), 0);
      if (v) sent++;
      cyc++;
      total++; if (bus.wr_en !== m_en || (m_en && (bus.wr_addr !== m_addr || bus.wr_data !== m_data)) || frame_done !== m_done) begin bad++; $display("FAIL gap_write: got en=%b addr=%0d data=%0d done=%b want %b %0d %0d %b", bus.wr_en, bus.wr_addr, bus.wr_data, frame_done, m_en, m_addr, m_data, m_done); end
      if (frame_done === 1'b1) ndone++;
    end
    total++; if (sent !== FRAME || ndone !== 1) begin bad++; $display("FAIL gap_complete: got sent=%0d done=%0d want %0d 1", sent, ndone, FRAME); end
  endtask

  task automatic test_clear();
    int nclr = 0, ndone = 0;
    cycle(1, 1, 2, 0);
    for (int i = 1; i < 8; i++) cycle(1, 0, DW'(i), 0);
    cycle(1, 0, 7, 1);
    total++; if (bus.wr_en !== 1'b0 || bus.pix_ready !== 1'b0 || short_frame !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL clr_start: got en=%b ready=%b short=%b busy=%b want 0 0 0 1", bus.wr_en, bus.pix_ready, short_frame, busy); end
    for (int i = 0; i < FRAME + 2; i++) begin
      cycle($urandom_range(0, 1) == 1, 0, DW'($urandom), 0);
      total++; if (bus.wr_en !== m_en || (m_en && (bus.wr_addr !== m_addr || bus.wr_data !== '0)) || frame_done !== m_done || bus.pix_ready !== m_ready) begin bad++; $display("FAIL clr_write: got en=%b addr=%0d data=%0d done=%b ready=%b want %b %0d 0 %b %b", bus.wr_en, bus.wr_addr, bus.wr_data, frame_done, bus.pix_ready, m_en, m_addr, m_done, m_ready); end
      if (bus.wr_en === 1'b1) begin
        nclr++;
        total++; if (bus.pix_ready !== 1'b0) begin bad++; $display("FAIL clr_ready: got %b want 0", bus.pix_ready); end
      end
      if (frame_done === 1'b1) ndone++;
    end
    total++; if (nclr !== FRAME || ndone !== 1) begin bad++; $display("FAIL clr_count: got writes=%0d done=%0d want %0d 1", nclr, ndone, FRAME); end
    // Restart mid-clear: addresses must begin again at 0.
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    total++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== '0) begin bad++; $display("FAIL clr_restart: got en=%b addr=%0d want 1 0", bus.wr_en, bus.wr_addr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, DW'($urandom), $urandom_range(0, 199) == 0);
      total++; if (bus.wr_en !== m_en || (m_en && (bus.wr_addr !== m_addr || bus.wr_data !== m_data)) || frame_done !== m_done) begin bad++; $display("FAIL rnd_write: got en=%b addr=%0d data=%0d done=%b want %b %0d %0d %b", bus.wr_en, bus.wr_addr, bus.wr_data, frame_done, m_en, m_addr, m_data, m_done); end
      total++; if (bus.pix_ready !== m_ready || busy !== m_busy || short_frame !== m_short) begin bad++; $display("FAIL rnd_ctrl: got ready=%b busy=%b short=%b want %b %b %b", bus.pix_ready, busy, short_frame, m_ready, m_busy, m_short); end
    end
  endtask

  initial begin
    reset_n = 1'b0; clear_req = 1'b0;
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_data = '0;
    model_reset();
    repeat (2) @(negedge clock);
    test_reset();
    test_full_frame();
    test_pre_sof_junk();
    test_early_sof();
    test_gaps();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
